fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one FIFO write port (2..4).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, byte/word width matching the FIFO.
REQ-003 SHALL have parameter TIMEOUT, default 255, idle cycles allowed before a held grant is revoked (1..255).
REQ-004 SHALL have port clk  input  1  clock; reset reset_n, synchronous, active-low; clock clk.
REQ-005 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester data valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed data, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_last  input  NUM_REQ  marks final beat of a message.
REQ-009 SHALL have port req_ready  output  NUM_REQ  beat accepted when valid&ready high at clk edge.
REQ-010 SHALL have port flush  input  1  single-cycle request to discard FIFO contents.
REQ-011 SHALL have port fifo_full  input  1  full flag from FIFO.
REQ-012 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-013 SHALL have port fifo_wr_data  output  DATA_WIDTH  FIFO write data.
REQ-014 SHALL have port fifo_clear  output  1  FIFO clear pulse.
REQ-015 SHALL have port grant_id  output  2  index of current owner, valid when busy.
REQ-016 SHALL have port busy  output  1  high in GRANT state.

Function
REQ-017 SHALL implement states IDLE, GRANT, FLUSH, registered.
REQ-018 IDLE: if flush -> FLUSH; else if any req_valid -> GRANT next cycle, owner = first valid requester searching upward (wrapping) from last_owner+1.
REQ-019 GRANT: req_ready[owner] = ~fifo_full; all other req_ready = 0; fifo_wr_en = req_valid[owner] & ~fifo_full; fifo_wr_data = owner's data (combinational from registered owner).
REQ-020 GRANT: beat accepted with req_last=1 -> IDLE; last_owner <= owner.
REQ-021 GRANT SHALL hold ownership across fifo_full stalls and gaps (message lock); no other requester interleaves.
REQ-022 Idle counter: cleared on each accepted beat and on GRANT entry; increments each GRANT cycle with req_valid[owner]=0; reaching TIMEOUT -> IDLE, last_owner <= owner.
REQ-023 Stall cycles (valid=1, fifo_full=1) SHALL NOT increment the idle counter.
REQ-024 flush in GRANT -> FLUSH regardless of pending beat; that cycle fifo_wr_en = 0 and all req_ready = 0.
REQ-025 FLUSH: fifo_clear = 1 for exactly one cycle, all req_ready = 0, fifo_wr_en = 0; then IDLE.
REQ-026 Grant latency: first beat accepted no earlier than 1 cycle after req_valid seen in IDLE; in IDLE all req_ready = 0.
REQ-027 flush has priority over new requests and over req_last completion in the same cycle.
REQ-028 Round-robin SHALL guarantee each continuously-requesting requester a grant within NUM_REQ-1 messages.

Reset
REQ-029 reset_n low SHALL force IDLE, last_owner = NUM_REQ-1 (so requester 0 wins first), idle counter 0, grant_id 0, busy 0, fifo_wr_en 0, fifo_clear 0, req_ready 0.
REQ-030 Reset mid-message SHALL abandon the message without any write; FIFO itself is reset separately.

Structure
REQ-031 State encodings and max NUM_REQ constant SHALL live in the shared UART package.
REQ-032 Round-robin next-owner selection SHALL be a sub-module rr_select (inputs mask, last index; output index, any).
REQ-033 Block SHALL be synthesizable for iCE40 with no inferred latches; all state in one clocked process.

Verification
REQ-034 Reset, req_valid=2'b11 -> grant_id=0 one cycle later; 3-beat message 0x41,0x42,0x43(last) -> three fifo_wr_en pulses, then grant_id=1.
REQ-035 Owner 0 mid-message, fifo_full=1 for 10 cycles -> no write, req_ready=0, grant held, no timeout; release -> writes resume in order.
REQ-036 TIMEOUT=4, owner drops valid without last -> IDLE after 4 idle cycles; next grant to other requester.
REQ-037 flush during GRANT -> fifo_clear high exactly one cycle, no write that cycle, IDLE after.
REQ-038 Both requesters streaming 1-beat messages for 8 messages -> grant alternates 0,1,0,1...
REQ-039 reset_n low mid-message -> all outputs at reset values next cycle, no write issued.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants and types for the FIFO write arbiter: FSM encodings,
// requester-count limit and the owner index type.
package fifo_write_arbiter_pkg;

  localparam int MAX_NUM_REQ = 4;
  localparam int OWNER_W     = 2;

  typedef logic [OWNER_W-1:0] owner_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Position reached by stepping 'offset' places upward from 'base', wrapping at n.
  function automatic int wrap_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_select.sv
// Round-robin pick: first set bit of mask searching upward from last+1, wrapping.
module rr_select
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] mask,
  input  owner_t             last,
  output owner_t             index,
  output logic               any
);

  always_comb begin
    index = '0;
    any   = |mask;
    // Walk from the farthest candidate to the nearest so the nearest match wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == wrap_index(int'(last), k, NUM_REQ) && mask[j]) begin
          index = owner_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one FIFO write port among NUM_REQ requesters with message locking,
// round-robin fairness, idle-grant timeout and a flush/clear path.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          flush,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_clear,
  output logic [1:0]                    grant_id,
  output logic                          busy
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam owner_t     LAST_INIT   = owner_t'(NUM_REQ - 1);

  logic [1:0] state_reg;
  owner_t     owner_reg;
  owner_t     last_owner_reg;
  logic [7:0] idle_cnt_reg;

  owner_t sel_index;
  logic   sel_any;
  logic   owner_valid;
  logic   owner_last;
  logic   write_ok;
  logic   accept;

  rr_select #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_select (
    .mask (req_valid),
    .last (last_owner_reg),
    .index(sel_index),
    .any  (sel_any)
  );

  always_comb begin
    owner_valid  = 1'b0;
    owner_last   = 1'b0;
    fifo_wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_reg == owner_t'(i)) begin
        owner_valid  = req_valid[i];
        owner_last   = req_last[i];
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset and flush both suppress the handshake in the cycle they are seen.
  assign write_ok = reset_n && (state_reg == ST_GRANT) && !flush && !fifo_full;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = write_ok && (owner_reg == owner_t'(i));
    end
  end

  assign fifo_wr_en = write_ok && owner_valid;
  assign accept     = fifo_wr_en;
  assign fifo_clear = reset_n && (state_reg == ST_FLUSH);
  assign busy       = (state_reg == ST_GRANT);
  assign grant_id   = owner_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= '0;
      last_owner_reg <= LAST_INIT;
      idle_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (flush) begin
            state_reg <= ST_FLUSH;
          end else if (sel_any) begin
            state_reg    <= ST_GRANT;
            owner_reg    <= sel_index;
            idle_cnt_reg <= '0;
          end
        end
        ST_GRANT: begin
          if (flush) begin
            state_reg <= ST_FLUSH;
          end else if (accept) begin
            idle_cnt_reg <= '0;
            if (owner_last) begin
              state_reg      <= ST_IDLE;
              last_owner_reg <= owner_reg;
            end
          end else if (!owner_valid) begin
            // Only true gaps count toward revocation; full-FIFO stalls do not.
            if (idle_cnt_reg + 8'd1 == TIMEOUT_CNT) begin
              state_reg      <= ST_IDLE;
              last_owner_reg <= owner_reg;
              idle_cnt_reg   <= '0;
            end else begin
              idle_cnt_reg <= idle_cnt_reg + 8'd1;
            end
          end
        end
        ST_FLUSH: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
